// File: rtl/restoring_divider_4bit_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the default operand width.
package restoring_divider_4bit_pkg;

    localparam int unsigned DIV_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/restoring_divider_4bit_trial_subtractor.sv
// Combinational trial subtractor: diff = a + ~b + 1 as a ripple of full adders.
// A carry-out of 1 means no borrow, so a >= b.
module restoring_divider_4bit_trial_subtractor #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         carry
);

    logic [W-1:0] nb;

    assign nb = ~b;

    always_comb begin
        logic [W:0] c;
        c    = '0;
        c[0] = 1'b1;
        diff = '0;
        for (int unsigned i = 0; i < W; i++) begin
            diff[i]  = a[i] ^ nb[i] ^ c[i];
            c[i+1]   = (a[i] & nb[i]) | (a[i] & c[i]) | (nb[i] & c[i]);
        end
        carry = c[W];
    end

endmodule

// File: rtl/restoring_divider_4bit.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/done handshake. Divide by zero finishes in one cycle with a flag.
module restoring_divider_4bit
    import restoring_divider_4bit_pkg::*;
#(
    parameter int unsigned N = DIV_N
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

    state_t        state, state_next;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  d_reg;
    logic [N:0]    r_reg;
    logic [CW-1:0] count;

    logic [N:0]    rs;
    logic [N:0]    diff;
    logic          carry;
    logic [N:0]    r_next;
    logic [N-1:0]  q_next;
    logic          last_iter;
    logic          r_msb_unused;

    // The partial remainder never exceeds the divisor, so its top bit is never
    // shifted back into the datapath.
    assign r_msb_unused = r_reg[N];

    assign rs        = {r_reg[N-1:0], q_reg[N-1]};
    assign r_next    = carry ? diff : rs;
    assign q_next    = {q_reg[N-2:0], carry};
    assign last_iter = (count == CW'(N - 1));

    restoring_divider_4bit_trial_subtractor #(
        .W(N + 1)
    ) u_trial (
        .a    (rs),
        .b    ({1'b0, d_reg}),
        .diff (diff),
        .carry(carry)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = (divisor == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (last_iter) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        q_reg       <= dividend;
                        d_reg       <= divisor;
                        r_reg       <= '0;
                        count       <= '0;
                        div_by_zero <= (divisor == '0);
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end
                    end
                end
                ST_RUN: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    count <= count + 1'b1;
                    if (last_iter) begin
                        quotient  <= q_next;
                        remainder <= r_next[N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule
